// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, buffers fetched words in a 2-entry FIFO, delivers {instr, pc} over valid/ready.
// Optional FETCH_PERF_CNT_EN builds a saturating delivered-instruction counter on o_fetch_count.
module instruction_fetch #(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 8,
  parameter int PROG_LEN = 6,
  parameter int RESET_PC = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic [PC_W-1:0]    o_pc_op,
  input  logic [INSTR_W-1:0] i_im_out,
  input  logic               i_stall,
  input  logic               i_branch_en,
  input  logic [PC_W-1:0]    i_branch_target,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_instr_pc,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic               o_bad_target,
  output logic [15:0]        o_fetch_count
);

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_head_instr, r_tail_instr;
  logic [PC_W-1:0]    r_head_pc, r_tail_pc;
  logic [1:0]         r_count;
  logic               r_bad_target;

  logic               w_pop, w_push, w_tgt_ok, w_wr_tail;
  logic [1:0]         w_wr_idx;
  logic [PC_W-1:0]    w_pc_next;

  assign o_instr_valid = (r_count != 2'd0);
  assign w_pop         = o_instr_valid & i_instr_ready;
  assign w_push        = ~i_stall & ~i_branch_en & ((r_count < 2'd2) | w_pop);
  assign w_tgt_ok      = ({1'b0, i_branch_target} < (PC_W+1)'(PROG_LEN));
  assign w_pc_next     = (r_pc == PC_W'(PROG_LEN - 1)) ? '0 : r_pc + 1'b1;
  // Tail slot after this cycle's pop has shifted the buffer forward.
  assign w_wr_idx      = r_count - {1'b0, w_pop};
  assign w_wr_tail     = w_wr_idx[0];

  assign o_pc_op       = r_pc;
  assign o_instr       = o_instr_valid ? r_head_instr : '0;
  assign o_instr_pc    = o_instr_valid ? r_head_pc : '0;
  assign o_bad_target  = r_bad_target;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc         <= PC_W'(RESET_PC);
      r_count      <= 2'd0;
      r_head_instr <= '0;
      r_head_pc    <= '0;
      r_tail_instr <= '0;
      r_tail_pc    <= '0;
      r_bad_target <= 1'b0;
    end else begin
      r_bad_target <= 1'b0;
      if (i_branch_en) begin
        r_count <= 2'd0;
        if (w_tgt_ok) begin
          r_pc <= i_branch_target;
        end else begin
          r_pc         <= '0;
          r_bad_target <= 1'b1;
        end
      end else begin
        if (w_pop) begin
          r_head_instr <= r_tail_instr;
          r_head_pc    <= r_tail_pc;
        end
        if (w_push) begin
          if (w_wr_tail) begin
            r_tail_instr <= i_im_out;
            r_tail_pc    <= r_pc;
          end else begin
            r_head_instr <= i_im_out;
            r_head_pc    <= r_pc;
          end
          r_pc <= w_pc_next;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_count;

  // Counts every handshake, including one that a same-cycle branch flushes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_count <= '0;
    end else if (w_pop && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`else
  assign o_fetch_count = '0;
`endif

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage for the 8-bit MIPS core. It owns the program counter and drives the instruction memory address. It captures the combinational instruction word into a 2-entry buffer and presents instructions, tagged with their PC, to decode over a valid/ready handshake. It also handles sequential wrap at program length, branch redirects with buffer flush, and external stall.

## Interface
Parameters:
- PC_W, 8, program counter and memory address width
- INSTR_W, 8, instruction width
- PROG_LEN, 6, number of valid program words; the PC wraps to 0 after PROG_LEN-1
- RESET_PC, 0, PC value loaded on reset; must be < PROG_LEN

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_op  out  PC_W  address to instruction memory (current fetch PC)
- im_out  in  INSTR_W  instruction memory read data, combinational from pc_op
- stall  in  1  freeze fetch; no PC advance, no buffer push
- branch_en  in  1  redirect request, single cycle
- branch_target  in  PC_W  redirect address
- instr  out  INSTR_W  buffer-head instruction
- instr_pc  out  PC_W  PC of buffer-head instruction
- instr_valid  out  1  buffer non-empty
- instr_ready  in  1  decode accepts head
- bad_target  out  1  one-cycle pulse: branch_target >= PROG_LEN
- fetch_count  out  16  delivered-instruction counter (see Configuration)

## Operation
- Registers: pc, a 2-entry FIFO of {instr, pc}, a count (0..2), bad_target, and fetch_count.
- pc_op = pc at all times.
- pop = instr_valid & instr_ready.
- push = !stall & !branch_en & (count < 2 | pop). On push, {im_out, pc} is written to the tail and pc advances: pc <= (pc == PROG_LEN-1) ? 0 : pc+1.
- Branch has priority over stall, push and pop:
  - The FIFO is flushed (count <= 0), including any entry being popped that cycle.
  - pc <= branch_target if branch_target < PROG_LEN. Otherwise pc <= 0 and bad_target <= 1 for one cycle.
- Stall with no branch: pc holds, no push. Pop is still honoured, so decode drains the buffer.
- Count update:
  - push & !pop: +1
  - pop & !push: −1
  - both: unchanged
- instr and instr_pc are 0 when the FIFO is empty.
- Reset values: pc = RESET_PC, count = 0, instr_valid = 0, instr = 0, instr_pc = 0, bad_target = 0, fetch_count = 0. Reset asserted mid-operation discards the buffer immediately (asynchronously).

## Timing
- Fetch-to-valid latency is 1 cycle. The word addressed in cycle N is instr at cycle N+1 if the FIFO was empty.
- The first instr_valid comes on the first rising edge after rst_n deasserts (pc = RESET_PC).
- With instr_ready held at 1 and no stall, throughput is one instruction per cycle and count stays at 1.
- Backpressure: with instr_ready = 0, the FIFO fills in 2 cycles and pc then holds. When ready returns, the head is delivered the same cycle and the refill push happens in that same cycle.
- Branch in cycle N: instr_valid = 0 at N+1, and the target instruction is valid at N+2.
- bad_target is high exactly one cycle, the cycle after the offending branch.
- The PC wraps with no bubble: PROG_LEN-1 is followed by 0 on consecutive cycles.

## Configuration
- FETCH_PERF_CNT_EN:
  - Defined: fetch_count increments on every pop, saturates at 16'hFFFF, is not cleared by a branch, and is cleared only by reset.
  - Undefined: no counter register is built and fetch_count is tied to 0.

## Test plan
The bench memory model holds 0x51, 0x92, 0x72, 0x12, 0x32, 0x12 at addresses 0–5 (PROG_LEN = 6).
- Reset release, instr_ready = 1, no stall -> instr sequence 0x51, 0x92, 0x72, 0x12, 0x32, 0x12, 0x51 with instr_pc 0, 1, 2, 3, 4, 5, 0 on consecutive cycles, starting 1 cycle after reset release.
- instr_ready = 0 for 5 cycles, then 1 -> count reaches 2, pc_op holds at 2, then 0x51, 0x92, 0x72 are delivered back-to-back with no loss or duplication.
- branch_en with branch_target = 4 while 2 entries are buffered -> instr_valid = 0 next cycle, then 0x32 with instr_pc = 4.
- branch_target = 9 -> bad_target high for 1 cycle, then instr 0x51 with instr_pc = 0.
- stall = 1 for 3 cycles with ready = 1 -> buffer drains to empty, pc_op is constant, and the sequence resumes with no skipped address; rst_n asserted mid-stream -> all outputs are 0 and pc_op = 0 immediately.
- With FETCH_PERF_CNT_EN defined -> fetch_count = 10 after 10 handshakes, and a branch does not clear it; with the macro undefined -> fetch_count stays 0.
